// File: rtl/regfile_sb.sv
// Register file with half-word immediate writes, carry/borrow flags and a per-register pending scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writes and flag updates to the read outputs.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int NUM_REG = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              clk_pi,
    input  logic              reset_pi,
    input  logic              clk_en_pi,
    input  logic [ADDR_W-1:0] src1_reg_pi,
    input  logic [ADDR_W-1:0] src2_reg_pi,
    input  logic [ADDR_W-1:0] dest_reg_pi,
    input  logic              wr_en_pi,
    input  logic [DATA_W-1:0] wr_data_pi,
    input  logic              movi_lower_pi,
    input  logic              movi_higher_pi,
    input  logic [DATA_W/2-1:0] immediate_pi,
    input  logic              flags_wr_pi,
    input  logic              new_carry_pi,
    input  logic              new_borrow_pi,
    input  logic              reserve_pi,
    input  logic [ADDR_W-1:0] reserve_reg_pi,
    output logic [DATA_W-1:0] reg1_data_po,
    output logic [DATA_W-1:0] reg2_data_po,
    output logic [DATA_W-1:0] regD_data_po,
    output logic              src1_pending_po,
    output logic              src2_pending_po,
    output logic              current_carry_po,
    output logic              current_borrow_po,
    output logic              reserve_err_po
);

    localparam int HALF_W = DATA_W / 2;

    logic [DATA_W-1:0]  regs [NUM_REG];
    logic [NUM_REG-1:0] pending;
    logic               carry;
    logic               borrow;
    logic               reserve_err;
    logic [DATA_W-1:0]  wr_value;

    // Merged write value; movi_lower takes priority over movi_higher.
    always_comb begin
        wr_value = wr_data_pi;
        if (movi_lower_pi)
            wr_value = {regs[dest_reg_pi][DATA_W-1:HALF_W], immediate_pi};
        else if (movi_higher_pi)
            wr_value = {immediate_pi, regs[dest_reg_pi][HALF_W-1:0]};
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            for (int unsigned i = 0; i < NUM_REG; i++)
                regs[ADDR_W'(i)] <= DATA_W'(i);
            pending     <= '0;
            carry       <= 1'b0;
            borrow      <= 1'b0;
            reserve_err <= 1'b0;
        end else if (clk_en_pi) begin
            if (wr_en_pi) begin
                regs[dest_reg_pi]    <= wr_value;
                pending[dest_reg_pi] <= 1'b0;
            end
            // Issued after the clear so a same-cycle reserve leaves the bit set.
            if (reserve_pi) begin
                pending[reserve_reg_pi] <= 1'b1;
                if (pending[reserve_reg_pi] && !(wr_en_pi && dest_reg_pi == reserve_reg_pi))
                    reserve_err <= 1'b1;
            end
            if (flags_wr_pi) begin
                carry  <= new_carry_pi;
                borrow <= new_borrow_pi;
            end
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic wr_fire;
    assign wr_fire = clk_en_pi & wr_en_pi & ~reset_pi;

    always_comb begin
        reg1_data_po = regs[src1_reg_pi];
        reg2_data_po = regs[src2_reg_pi];
        regD_data_po = regs[dest_reg_pi];
        if (wr_fire && src1_reg_pi == dest_reg_pi)
            reg1_data_po = wr_value;
        if (wr_fire && src2_reg_pi == dest_reg_pi)
            reg2_data_po = wr_value;
        if (wr_fire)
            regD_data_po = wr_value;
    end

    always_comb begin
        current_carry_po  = carry;
        current_borrow_po = borrow;
        if (clk_en_pi && flags_wr_pi) begin
            current_carry_po  = new_carry_pi;
            current_borrow_po = new_borrow_pi;
        end
    end
`else
    always_comb begin
        reg1_data_po = regs[src1_reg_pi];
        reg2_data_po = regs[src2_reg_pi];
        regD_data_po = regs[dest_reg_pi];
    end

    always_comb begin
        current_carry_po  = carry;
        current_borrow_po = borrow;
    end
`endif

    assign src1_pending_po = pending[src1_reg_pi];
    assign src2_pending_po = pending[src2_reg_pi];
    assign reserve_err_po  = reserve_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb; expectations track REGFILE_SB_BYPASS_EN when it is defined.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [2:0]  src1, src2, dest, reserve_reg;
    logic        wr_en, movi_lower, movi_higher;
    logic [15:0] wr_data;
    logic [7:0]  imm;
    logic        flags_wr, new_carry, new_borrow, reserve;
    logic [15:0] reg1, reg2, regd;
    logic        p1, p2, carry, borrow, err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(16), .NUM_REG(8), .ADDR_W(3)) dut (
        .clk_pi(clk), .reset_pi(reset), .clk_en_pi(clk_en),
        .src1_reg_pi(src1), .src2_reg_pi(src2), .dest_reg_pi(dest),
        .wr_en_pi(wr_en), .wr_data_pi(wr_data),
        .movi_lower_pi(movi_lower), .movi_higher_pi(movi_higher), .immediate_pi(imm),
        .flags_wr_pi(flags_wr), .new_carry_pi(new_carry), .new_borrow_pi(new_borrow),
        .reserve_pi(reserve), .reserve_reg_pi(reserve_reg),
        .reg1_data_po(reg1), .reg2_data_po(reg2), .regD_data_po(regd),
        .src1_pending_po(p1), .src2_pending_po(p2),
        .current_carry_po(carry), .current_borrow_po(borrow),
        .reserve_err_po(err)
    );

    typedef struct {
        logic        en, we;
        logic [2:0]  dest;
        logic [15:0] wdata;
        logic        ml, mh;
        logic [7:0]  imm;
        logic        fw, nc, nb, rsv;
        logic [2:0]  rreg, s1, s2;
        logic [15:0] r1, r2, rd;
        logic        p1, p2, c, b, err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [52:0] outs();
        return {reg1, reg2, regd, p1, p2, carry, borrow, err};
    endfunction

    task automatic idle();
        wr_en = 0; movi_lower = 0; movi_higher = 0; flags_wr = 0; reserve = 0;
        new_carry = 0; new_borrow = 0; imm = '0; wr_data = '0; reserve_reg = '0;
    endtask

    initial begin
        reset = 1; clk_en = 0; src1 = 5; src2 = 0; dest = 5;
        idle();
        @(negedge clk);
        @(posedge clk); #1 reset = 0; #1;
        check("reset_state", {reg1, regd, p1, p2, carry, borrow, err},
              {16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        //          en we d  wdata    ml mh imm    fw nc nb rsv rr s1 s2 | r1       r2       rd       p1 p2 c  b  err
        vecs[0]  = '{1, 1, 3, 16'h1234, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 5, 16'h1234, 16'h0005, 16'h1234, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 3, 16'hFFFF, 1, 0, 8'hAB, 0, 0, 0, 0, 0, 3, 0, 16'h12AB, 16'h0000, 16'h12AB, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 3, 16'hFFFF, 0, 1, 8'hCD, 0, 0, 0, 0, 0, 3, 0, 16'hCDAB, 16'h0000, 16'hCDAB, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 3, 16'hFFFF, 1, 1, 8'h00, 0, 0, 0, 0, 0, 3, 0, 16'hCD00, 16'h0000, 16'hCD00, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 3, 16'hFFFF, 1, 0, 8'h55, 0, 0, 0, 0, 0, 3, 0, 16'hCD00, 16'h0000, 16'hCD00, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 3, 16'h0000, 0, 0, 8'h00, 1, 1, 0, 0, 0, 3, 5, 16'hCD00, 16'h0005, 16'hCD00, 0, 0, 1, 0, 0};
        vecs[6]  = '{1, 0, 3, 16'h0000, 0, 0, 8'h00, 1, 0, 1, 0, 0, 3, 5, 16'hCD00, 16'h0005, 16'hCD00, 0, 0, 0, 1, 0};
        vecs[7]  = '{1, 0, 3, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 3, 5, 16'hCD00, 16'h0005, 16'hCD00, 0, 0, 0, 1, 0};
        vecs[8]  = '{1, 0, 3, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 1, 2, 2, 3, 16'h0002, 16'hCD00, 16'hCD00, 1, 0, 0, 1, 0};
        vecs[9]  = '{1, 1, 2, 16'hBEEF, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 3, 16'hBEEF, 16'hCD00, 16'hBEEF, 0, 0, 0, 1, 0};
        vecs[10] = '{1, 1, 4, 16'h4444, 0, 0, 8'h00, 0, 0, 0, 1, 4, 4, 2, 16'h4444, 16'hBEEF, 16'h4444, 1, 0, 0, 1, 0};
        vecs[11] = '{0, 1, 4, 16'h9999, 0, 0, 8'h00, 1, 1, 0, 1, 5, 4, 5, 16'h4444, 16'h0005, 16'h4444, 1, 0, 0, 1, 0};
        vecs[12] = '{1, 0, 4, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 1, 4, 4, 5, 16'h4444, 16'h0005, 16'h4444, 1, 0, 0, 1, 1};
        vecs[13] = '{1, 1, 4, 16'h0001, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4, 2, 16'h0001, 16'hBEEF, 16'h0001, 0, 0, 0, 1, 1};

        // Strobes drop 1 ns after the edge so only registered state is observed.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            clk_en = vecs[i].en; wr_en = vecs[i].we; dest = vecs[i].dest; wr_data = vecs[i].wdata;
            movi_lower = vecs[i].ml; movi_higher = vecs[i].mh; imm = vecs[i].imm;
            flags_wr = vecs[i].fw; new_carry = vecs[i].nc; new_borrow = vecs[i].nb;
            reserve = vecs[i].rsv; reserve_reg = vecs[i].rreg; src1 = vecs[i].s1; src2 = vecs[i].s2;
            @(posedge clk); #1;
            idle(); clk_en = 1; #1;
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].r1, vecs[i].r2, vecs[i].rd, vecs[i].p1, vecs[i].p2, vecs[i].c, vecs[i].b, vecs[i].err});
        end

        // Reset beats a same-cycle write, reserve and flag update.
        @(negedge clk);
        reset = 1; clk_en = 1; wr_en = 1; dest = 5; wr_data = 16'hFFFF;
        reserve = 1; reserve_reg = 6; flags_wr = 1; new_carry = 1; new_borrow = 1;
        src1 = 5; src2 = 6;
        @(posedge clk); #1 reset = 0; idle(); #1;
        check("reset_priority", outs(), {16'h0005, 16'h0006, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Pending has no same-cycle forwarding.
        @(negedge clk);
        reserve = 1; reserve_reg = 7; src1 = 7; #1;
        check("pending_no_fwd", {31'd0, p1}, 32'd0);
        @(posedge clk); #1 idle(); #1;
        check("pending_after", {31'd0, p1}, 32'd1);

        // Same-cycle read of a write in progress.
        @(negedge clk);
        src1 = 6; src2 = 6; dest = 6; wr_en = 1; wr_data = 16'h0F0F;
        flags_wr = 1; new_carry = 1; new_borrow = 1; #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("bypass_write", {reg1, reg2, regd, carry, borrow}, {16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b1, 1'b1});
`else
        check("bypass_write", {reg1, reg2, regd, carry, borrow}, {16'h0006, 16'h0006, 16'h0006, 1'b0, 1'b0});
`endif
        @(posedge clk); #1 idle(); #1;
        check("after_write", {reg1, carry, borrow}, {16'h0F0F, 1'b1, 1'b1});

        @(negedge clk);
        wr_en = 1; movi_lower = 1; imm = 8'h77; #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("bypass_movi", {48'd0, reg1}, {48'd0, 16'h0F77});
`else
        check("bypass_movi", {48'd0, reg1}, {48'd0, 16'h0F0F});
`endif
        @(posedge clk); #1 idle(); #1;
        check("after_movi", {48'd0, reg1}, {48'd0, 16'h0F77});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and data width in bits (even, >= 4).
REQ-002 SHALL have parameter NUM_REG, default 8, number of architectural registers (power of two, >= 2).
REQ-003 SHALL have parameter ADDR_W, default 3, register index width, equal to log2(NUM_REG).
REQ-004 SHALL have clk_pi  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have reset_pi  input  1  synchronous, active-high reset.
REQ-006 SHALL have clk_en_pi  input  1  global update enable for registers, flags and scoreboard.
REQ-007 SHALL have src1_reg_pi, src2_reg_pi  input  ADDR_W each  read-port indices.
REQ-008 SHALL have dest_reg_pi  input  ADDR_W  write index and store-data read index.
REQ-009 SHALL have wr_en_pi  input  1  write request to dest_reg_pi.
REQ-010 SHALL have wr_data_pi  input  DATA_W  full-width write data.
REQ-011 SHALL have movi_lower_pi, movi_higher_pi  input  1 each  half-word immediate write select.
REQ-012 SHALL have immediate_pi  input  DATA_W/2  immediate data.
REQ-013 SHALL have flags_wr_pi, new_carry_pi, new_borrow_pi  input  1 each  flag update enable and values.
REQ-014 SHALL have reserve_pi  input  1, and reserve_reg_pi  input  ADDR_W  mark a register pending.
REQ-015 SHALL have reg1_data_po, reg2_data_po, regD_data_po  output  DATA_W each  read data.
REQ-016 SHALL have src1_pending_po, src2_pending_po  output  1 each  scoreboard bit of src1/src2 index.
REQ-017 SHALL have current_carry_po, current_borrow_po  output  1 each  flag state.
REQ-018 SHALL have reserve_err_po  output  1  sticky error: reserve of an already-pending register.

Function
REQ-019 SHALL read all three data ports combinationally from the register array at their indices.
REQ-020 SHALL perform no state update in a cycle where clk_en_pi=0 and reset_pi=0.
REQ-021 SHALL, on clk_en_pi=1 and wr_en_pi=1 with both movi selects low, write wr_data_pi to register dest_reg_pi.
REQ-022 SHALL, on write with movi_lower_pi=1, replace bits [DATA_W/2-1:0] with immediate_pi and keep the upper half.
REQ-023 SHALL, on write with movi_higher_pi=1 and movi_lower_pi=0, replace bits [DATA_W-1:DATA_W/2] and keep the lower half.
REQ-024 SHALL give movi_lower_pi priority when both movi selects are high.
REQ-025 SHALL ignore movi selects and immediate_pi when wr_en_pi=0.
REQ-026 SHALL update both flags from new_carry_pi/new_borrow_pi only when clk_en_pi=1 and flags_wr_pi=1.
REQ-027 SHALL hold one pending bit per register; an enabled write to a register clears its bit.
REQ-028 SHALL set the pending bit of reserve_reg_pi on clk_en_pi=1 and reserve_pi=1.
REQ-029 SHALL let set win over clear when reserve and write target the same register in one cycle.
REQ-030 SHALL drive src1/src2_pending_po from the registered scoreboard only (no same-cycle forwarding).
REQ-031 SHALL set reserve_err_po when a reserve hits a register whose bit is already set and no write clears it that cycle; the register stays pending and the flag holds until reset.

Reset
REQ-032 SHALL, on reset_pi=1 at a clock edge regardless of clk_en_pi, load register i with value i (zero-extended to DATA_W).
REQ-033 SHALL, on reset, clear both flags, all pending bits and reserve_err_po.
REQ-034 SHALL give reset priority over every write, reserve and flag update in the same cycle.
REQ-035 SHALL, after reset, present reg1_data_po=src1 index, pending outputs 0, and flag outputs 0.

Configuration
REQ-036 SHALL provide macro REGFILE_SB_BYPASS_EN enabling write-to-read forwarding.
REQ-037 SHALL, with REGFILE_SB_BYPASS_EN defined, make every read port whose index matches an enabled, non-reset write that cycle return the post-write value, including the half-word merge.
REQ-038 SHALL, without REGFILE_SB_BYPASS_EN, make reads return the pre-write register value during the writing cycle.
REQ-039 SHALL, with REGFILE_SB_BYPASS_EN defined, also forward flag outputs from new_carry_pi/new_borrow_pi when clk_en_pi=1 and flags_wr_pi=1.

Verification
REQ-040 SHALL check reset: reset_pi=1 for 1 cycle, clk_en_pi=0 -> reg[5]=0x0005, flags 0, pending 0, reserve_err_po=0.
REQ-041 SHALL check movi: reg[3]=0x1234; write movi_lower imm 0xAB -> 0x12AB; then movi_higher imm 0xCD -> 0xCDAB; both high with imm 0x00 -> 0xCD00.
REQ-042 SHALL check the scoreboard: reserve reg 2 -> src1_pending_po=1 next cycle; write reg 2 with 0xBEEF -> pending 0, reg1_data_po=0xBEEF.
REQ-043 SHALL check collisions: reserve and write reg 4 in one cycle -> reg[4] updated, pending stays 1; reserve reg 4 again -> reserve_err_po=1 until reset.
REQ-044 SHALL check enable gating: clk_en_pi=0 with wr_en_pi=1, reserve_pi=1, flags_wr_pi=1 -> no change to any register, pending bit or flag.
REQ-045 SHALL check bypass: src1=dest=6, write 0x0F0F -> reg1_data_po=0x0F0F same cycle with macro, 0x0006 without.
